// File: rtl/imsic_msi_rcv.sv
// IMSIC MSI receiver: synchronizes a stretched MSI valid level, decodes the
// captured {hart, file, src} word and issues one set-pending pulse per MSI.
module imsic_msi_rcv #(
    parameter int NR_SRC_WIDTH    = 8,
    parameter int INTP_FILE_WIDTH = 3,
    parameter int NR_HARTS_WIDTH  = 6,
    parameter int NR_INTP_FILES   = 7,
    parameter int HART_ID         = 0,
    localparam int MSI_INFO_WIDTH =
        NR_HARTS_WIDTH + INTP_FILE_WIDTH + NR_SRC_WIDTH
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [MSI_INFO_WIDTH-1:0] msi_info,
    input  logic                      msi_info_vld,
    output logic                      setipnum_vld,
    output logic [NR_SRC_WIDTH-1:0]   setipnum,
    output logic [NR_INTP_FILES-1:0]  setipnum_file,
    output logic [7:0]                err_cnt,
    output logic                      busy
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_LOW
    } state_t;

    localparam logic [NR_HARTS_WIDTH-1:0] MY_HART =
        NR_HARTS_WIDTH'(HART_ID);
    localparam logic [NR_INTP_FILES-1:0] FILE_ONE =
        NR_INTP_FILES'(1);

    state_t state;

    logic sync_q;
    logic vld_s;
    logic vld_s_d;
    logic rise;

    logic [MSI_INFO_WIDTH-1:0]  info_q;
    logic [NR_HARTS_WIDTH-1:0]  hart_idx;
    logic [INTP_FILE_WIDTH-1:0] file_idx;
    logic [NR_SRC_WIDTH-1:0]    src_id;
    logic                       hit;
    logic                       legal;

    // msi_info_vld may come from another clock domain
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q  <= 1'b0;
            vld_s   <= 1'b0;
            vld_s_d <= 1'b0;
        end else begin
            sync_q  <= msi_info_vld;
            vld_s   <= sync_q;
            vld_s_d <= vld_s;
        end
    end

    assign rise = vld_s & ~vld_s_d;

    assign hart_idx = info_q[MSI_INFO_WIDTH-1 -: NR_HARTS_WIDTH];
    assign file_idx = info_q[NR_SRC_WIDTH +: INTP_FILE_WIDTH];
    assign src_id   = info_q[NR_SRC_WIDTH-1:0];

    assign hit   = (hart_idx == MY_HART);
    assign legal = (32'(file_idx) < 32'(NR_INTP_FILES)) &&
                   (src_id != '0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= IDLE;
            info_q        <= '0;
            setipnum_vld  <= 1'b0;
            setipnum      <= '0;
            setipnum_file <= '0;
            err_cnt       <= 8'd0;
        end else begin
            setipnum_vld <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (rise) begin
                        info_q <= msi_info;
                        state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= WAIT_LOW;
                    if (hit) begin
                        if (legal) begin
                            setipnum_vld  <= 1'b1;
                            setipnum      <= src_id;
                            setipnum_file <= FILE_ONE << file_idx;
                        end else if (err_cnt != 8'hff) begin
                            err_cnt <= err_cnt + 8'd1;
                        end
                    end
                end
                WAIT_LOW: begin
                    if (!vld_s) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_imsic_msi_rcv.sv
// Scoreboard bench for imsic_msi_rcv: stimulus pushes expected pulses,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_imsic_msi_rcv;

    typedef struct {
        logic [7:0] src;
        logic [6:0] file;
        int         cyc;
    } exp_t;

    logic        clk;
    logic        rstn;
    logic [16:0] msi_info;
    logic        msi_info_vld;
    logic        setipnum_vld;
    logic [7:0]  setipnum;
    logic [6:0]  setipnum_file;
    logic [7:0]  err_cnt;
    logic        busy;

    int   cyc;
    int   n_chk;
    int   n_pass;
    int   err_m;
    logic [7:0] last_src;
    logic [6:0] last_file;
    exp_t q[$];

    imsic_msi_rcv #(
        .NR_SRC_WIDTH   (8),
        .INTP_FILE_WIDTH(3),
        .NR_HARTS_WIDTH (6),
        .NR_INTP_FILES  (7),
        .HART_ID        (3)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .msi_info     (msi_info),
        .msi_info_vld (msi_info_vld),
        .setipnum_vld (setipnum_vld),
        .setipnum     (setipnum),
        .setipnum_file(setipnum_file),
        .err_cnt      (err_cnt),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Monitor: every observed pulse must match the oldest expectation
    always @(negedge clk) begin
        if (rstn && setipnum_vld) begin
            if (q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_pulse: got src %0d at cycle %0d expected none",
                         setipnum, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("pulse_src", 32'(setipnum), 32'(e.src));
                chk("pulse_file", 32'(setipnum_file), 32'(e.file));
                chk("pulse_cycle", cyc, e.cyc);
            end
        end
    end

    // Called just after a posedge; returns just after a posedge.
    // hi+lo must be at least 4 so the MSI has been issued on return.
    task automatic send(input logic [5:0] h, input logic [2:0] f,
                        input logic [7:0] s, input int hi, input int lo);
        exp_t e;
        msi_info     = {h, f, s};
        msi_info_vld = 1'b1;
        if (h == 6'd3) begin
            if (int'(f) < 7 && s != 8'd0) begin
                e.src  = s;
                e.file = 7'd1 << f;
                e.cyc  = cyc + 4;
                q.push_back(e);
                last_src  = s;
                last_file = 7'd1 << f;
            end else if (err_m < 255) begin
                err_m++;
            end
        end
        repeat (hi) @(posedge clk);
        #1 msi_info_vld = 1'b0;
        repeat (lo) @(posedge clk);
        #1;
        chk("err_cnt", 32'(err_cnt), err_m);
        chk("hold_src", 32'(setipnum), 32'(last_src));
        chk("hold_file", 32'(setipnum_file), 32'(last_file));
    endtask

    initial begin
        exp_t e;
        logic [5:0] h;
        n_chk        = 0;
        n_pass       = 0;
        err_m        = 0;
        last_src     = 8'd0;
        last_file    = 7'd0;
        rstn         = 1'b0;
        msi_info     = '0;
        msi_info_vld = 1'b0;

        #3;
        chk("rst_vld", 32'(setipnum_vld), 0);
        chk("rst_src", 32'(setipnum), 0);
        chk("rst_file", 32'(setipnum_file), 0);
        chk("rst_err", 32'(err_cnt), 0);
        chk("rst_busy", 32'(busy), 0);
        msi_info_vld = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk("rst_busy_clk", 32'(busy), 0);
        chk("rst_vld_clk", 32'(setipnum_vld), 0);
        msi_info_vld = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // legal MSI, long level
        send(6'd3, 3'd2, 8'd5, 8, 3);
        // other hart dropped, then illegal file, then src 0
        send(6'd4, 3'd0, 8'd9, 8, 3);
        send(6'd3, 3'd7, 8'd9, 8, 3);
        send(6'd3, 3'd1, 8'd0, 8, 3);
        // long level, single-cycle gap, then file 0
        send(6'd3, 3'd5, 8'd17, 20, 1);
        send(6'd3, 3'd0, 8'd200, 8, 3);
        // stream of 16 legal MSIs
        for (int i = 0; i < 16; i++)
            send(6'd3, 3'(i % 7), 8'(i + 1), 8, 3);
        // saturation
        for (int i = 0; i < 260; i++)
            send(6'd3, 3'd7, 8'd1, 3, 1);
        chk("err_sat", 32'(err_cnt), 255);

        // reset while in ISSUE with the level still high
        msi_info     = {6'd3, 3'd4, 8'd77};
        msi_info_vld = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("busy_issue", 32'(busy), 1);
        rstn = 1'b0;
        #1;
        chk("abort_vld", 32'(setipnum_vld), 0);
        chk("abort_src", 32'(setipnum), 0);
        chk("abort_file", 32'(setipnum_file), 0);
        chk("abort_err", 32'(err_cnt), 0);
        chk("abort_busy", 32'(busy), 0);
        err_m     = 0;
        last_src  = 8'd0;
        last_file = 7'd0;
        repeat (2) @(negedge clk);
        rstn   = 1'b1;
        e.src  = 8'd77;
        e.file = 7'b0010000;
        e.cyc  = cyc + 4;
        q.push_back(e);
        last_src  = 8'd77;
        last_file = 7'b0010000;
        repeat (8) @(posedge clk);
        #1 msi_info_vld = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_src", 32'(setipnum), 77);

        // randomized traffic
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                h = 6'd3;
            end else begin
                h = 6'($urandom_range(0, 63));
                if (h == 6'd3) h = 6'd4;
            end
            send(h, 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255)),
                 int'($urandom_range(3, 10)), int'($urandom_range(1, 4)));
        end

        repeat (10) @(posedge clk);
        #1 chk("queue_empty", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/imsic_msi_rcv.md
IMSIC_MSI_RCV -- requirements
Module: imsic_msi_rcv

Interface
- REQ-001: Parameter NR_SRC_WIDTH, default 8: interrupt identity width.
- REQ-002: Parameter INTP_FILE_WIDTH, default 3: interrupt file index width.
- REQ-003: Parameter NR_HARTS_WIDTH, default 6: hart index width.
- REQ-004: Parameter NR_INTP_FILES, default 7: number of files per hart (M plus S/VS), at least 2.
- REQ-005: Parameter HART_ID, default 0: hart index this instance serves.
- REQ-006: Local parameter MSI_INFO_WIDTH SHALL equal NR_HARTS_WIDTH+INTP_FILE_WIDTH+NR_SRC_WIDTH (17 at defaults).
- REQ-007: The block SHALL use one clock, and its reset SHALL be asynchronous and active-low.
- REQ-008: clk, input, 1: the only clock.
- REQ-009: rstn, input, 1: asynchronous active-low reset.
- REQ-010: msi_info, input, MSI_INFO_WIDTH: {hart[top], file[mid], src[low]}; stable whenever msi_info_vld is high.
- REQ-011: msi_info_vld, input, 1: stretched valid level, one level per MSI, possibly from another domain.
- REQ-012: setipnum_vld, output, 1: one-cycle set-pending pulse.
- REQ-013: setipnum, output, NR_SRC_WIDTH: interrupt identity to set.
- REQ-014: setipnum_file, output, NR_INTP_FILES: one-hot target file (bit0 = M file).
- REQ-015: err_cnt, output, 8: saturating count of illegal MSIs.
- REQ-016: busy, output, 1: high whenever the state machine is not IDLE.

Function
- REQ-017: msi_info_vld SHALL pass through a 2-flop synchronizer to give vld_s; a registered copy vld_s_d SHALL be kept; rise = vld_s & ~vld_s_d.
- REQ-018: The state machine SHALL have states IDLE, ISSUE and WAIT_LOW, and SHALL reset to IDLE.
- REQ-019: IDLE with rise: capture msi_info into info_q and go to ISSUE. IDLE without rise: stay.
- REQ-020: ISSUE SHALL last exactly one cycle, register the decode of info_q into the outputs, and go to WAIT_LOW.
- REQ-021: WAIT_LOW SHALL stay while vld_s=1 and go to IDLE when vld_s=0; a rise is never accepted outside IDLE.
- REQ-022: Decode: hart = info_q top NR_HARTS_WIDTH bits, file = next INTP_FILE_WIDTH bits, src = low NR_SRC_WIDTH bits.
- REQ-023: hart != HART_ID SHALL silently drop the MSI: no pulse, err_cnt unchanged.
- REQ-024: hart == HART_ID with (file >= NR_INTP_FILES or src == 0) SHALL be illegal: no pulse, err_cnt+1 saturating at 255.
- REQ-025: Otherwise, on leaving ISSUE: setipnum_vld=1 for exactly one cycle, setipnum=src, setipnum_file=1<<file.
- REQ-026: setipnum and setipnum_file SHALL hold their last values until the next legal MSI; setipnum_vld SHALL otherwise be 0.
- REQ-027: Latency: if edge E1 is the first to sample msi_info_vld=1, info_q SHALL load at E3 and setipnum_vld SHALL be high from E4 to E5.
- REQ-028: A level held high any number of cycles SHALL produce at most one pulse.
- REQ-029: A low gap of 1 cycle or more on msi_info_vld, after leaving WAIT_LOW, SHALL let the next high level be accepted.
- REQ-030: busy SHALL equal (state != IDLE).

Reset
- REQ-031: While rstn=0, regardless of clk, all of the following SHALL be 0: synchronizer flops, vld_s_d, info_q, setipnum_vld, setipnum, setipnum_file, err_cnt, busy; state SHALL be IDLE.
- REQ-032: Reset asserted mid-operation (ISSUE or WAIT_LOW) SHALL abort the MSI: no pulse after reset release.
- REQ-033: After reset release, a msi_info_vld already high SHALL be seen as a rise and processed once.

Verification
- REQ-034: HART_ID=3; msi_info={6'd3,3'd2,8'd5}, msi_info_vld high 8 cycles -> setipnum_vld high exactly in cycle E4-E5, setipnum=5, setipnum_file=7'b0000100, err_cnt=0.
- REQ-035: HART_ID=3; msi_info={6'd4,3'd0,8'd9} -> no pulse, err_cnt stays 0; msi_info={6'd3,3'd7,8'd9} -> no pulse, err_cnt=1; then {6'd3,3'd1,8'd0} -> err_cnt=2.
- REQ-036: msi_info_vld held high 20 cycles -> exactly one pulse; low 1 cycle, then high with src=8'd200, file=0 -> second pulse, setipnum=200, setipnum_file=7'b0000001.
- REQ-037: rstn asserted while busy=1 in ISSUE -> all outputs 0 immediately, no pulse afterwards; with msi_info_vld still high at release -> exactly one pulse 4 edges after release.
- REQ-038: 260 illegal MSIs back to back -> err_cnt=255 and it does not wrap.
- REQ-039: Back-to-back 8-cycle-high/3-cycle-low stream of 16 legal MSIs with incrementing src -> 16 pulses, in order, with no loss.
